// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA boot loader: register map, status bits, state encodings
// and default protocol bytes.
package acia_pkg;

   localparam logic [1:0] RS_DATA   = 2'b00;
   localparam logic [1:0] RS_STATUS = 2'b01;
   localparam logic [1:0] RS_CTRL   = 2'b11;

   localparam int STAT_RX_AVAIL = 3;
   localparam int STAT_TX_READY = 4;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'h4C;
   localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
   localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CFG,
      ST_POLL_RX,
      ST_READ_RX,
      ST_PARSE,
      ST_WRITE_MEM,
      ST_POLL_TX,
      ST_WRITE_TX,
      ST_FIN
   } loader_state_e;

   typedef enum logic [2:0] {
      FLD_SYNC,
      FLD_ADDR_HI,
      FLD_ADDR_LO,
      FLD_LEN_HI,
      FLD_LEN_LO,
      FLD_DATA,
      FLD_CSUM
   } loader_field_e;

endpackage

// File: rtl/acia_boot_loader_if.sv
// ACIA register port and RAM write port as seen by the boot loader (master) and the
// muxed peripherals (slave).
interface acia_boot_loader_if;

   logic [1:0]  acia_rs;
   logic        acia_we;
   logic        acia_en;
   logic [7:0]  acia_din;
   logic [7:0]  acia_dout;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;

   modport master (
      output acia_rs, acia_we, acia_en, acia_din, mem_addr, mem_wdata, mem_we,
      input  acia_dout
   );

   modport slave (
      input  acia_rs, acia_we, acia_en, acia_din, mem_addr, mem_wdata, mem_we,
      output acia_dout
   );

endinterface

// File: rtl/acia_boot_loader_timer.sv
// loader_timer: loadable down-counter; expired_o is high once LOAD enabled cycles have
// elapsed since the last clear.
module loader_timer #(
   parameter int               WIDTH = 26,
   parameter logic [WIDTH-1:0] LOAD  = '1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = LOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/acia_boot_loader.sv
// acia_boot_loader: receives a framed image through the ACIA, writes it to RAM and replies
// ACK/NAK. Define LOADER_CHECKSUM_EN to add the trailing checksum field.
module acia_boot_loader
   import acia_pkg::*;
#(
   parameter logic [3:0] BAUD_SEL       = 4'h0,
   parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
   parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
   parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE,
   parameter int         TIMEOUT_CYCLES = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   output logic               busy_o,
   output logic               cpu_hold_o,
   output logic               done_o,
   output logic               error_o,
   acia_boot_loader_if.master bus
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   loader_state_e state_q, state_d;
   loader_field_e field_q, field_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    byte_q, byte_d;
   logic          error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   logic       tmr_clear, tmr_en, tmr_expired;
   logic       data_done;
   logic       acia_en, acia_we, mem_we;
   logic [1:0] acia_rs;
   logic [7:0] acia_din;

   loader_timer #(
      .WIDTH (TMR_W),
      .LOAD  (TMR_W'(TIMEOUT_CYCLES))
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (tmr_clear),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      addr_d    = addr_q;
      len_d     = len_q;
      byte_d    = byte_q;
      error_d   = error_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d     = sum_q;
`endif
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      data_done = 1'b0;
      acia_en   = 1'b0;
      acia_we   = 1'b0;
      acia_rs   = RS_DATA;
      acia_din  = 8'h00;
      mem_we    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_CFG;
               field_d   = FLD_SYNC;
               error_d   = 1'b0;
               tmr_clear = 1'b1;
            end
         end
         ST_CFG: begin
            acia_en  = 1'b1;
            acia_we  = 1'b1;
            acia_rs  = RS_CTRL;
            acia_din = {4'h0, BAUD_SEL};
            state_d  = ST_POLL_RX;
         end
         ST_POLL_RX: begin
            acia_en = 1'b1;
            acia_rs = RS_STATUS;
            tmr_en  = (field_q != FLD_SYNC);
            if (bus.acia_dout[STAT_RX_AVAIL]) begin
               state_d = ST_READ_RX;
            end else if (tmr_expired && (field_q != FLD_SYNC)) begin
               error_d = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_READ_RX: begin
            // Single pop per byte: the data is captured in this same cycle.
            acia_en   = 1'b1;
            acia_rs   = RS_DATA;
            byte_d    = bus.acia_dout;
            tmr_clear = 1'b1;
            state_d   = ST_PARSE;
         end
         ST_PARSE: begin
            state_d = ST_POLL_RX;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + byte_q;
`endif
            case (field_q)
               FLD_SYNC: begin
                  if (byte_q == SYNC_BYTE) begin
                     field_d = FLD_ADDR_HI;
`ifdef LOADER_CHECKSUM_EN
                     sum_d   = 8'h00;
`endif
                  end
               end
               FLD_ADDR_HI: begin
                  addr_d[15:8] = byte_q;
                  field_d      = FLD_ADDR_LO;
               end
               FLD_ADDR_LO: begin
                  addr_d[7:0] = byte_q;
                  field_d     = FLD_LEN_HI;
               end
               FLD_LEN_HI: begin
                  len_d[15:8] = byte_q;
                  field_d     = FLD_LEN_LO;
               end
               FLD_LEN_LO: begin
                  len_d[7:0] = byte_q;
                  if ({len_q[15:8], byte_q} == 16'h0000) begin
                     data_done = 1'b1;
                  end else begin
                     field_d = FLD_DATA;
                  end
               end
               FLD_DATA: begin
                  state_d = ST_WRITE_MEM;
               end
`ifdef LOADER_CHECKSUM_EN
               FLD_CSUM: begin
                  // A good frame sums to zero including the checksum byte.
                  state_d = ST_POLL_TX;
                  if ((sum_q + byte_q) != 8'h00) begin
                     error_d = 1'b1;
                  end
               end
`endif
               default: begin
                  field_d = FLD_SYNC;
               end
            endcase
         end
         ST_WRITE_MEM: begin
            mem_we  = 1'b1;
            addr_d  = addr_q + 16'h0001;
            len_d   = len_q - 16'h0001;
            state_d = ST_POLL_RX;
            if (len_q == 16'h0001) begin
               data_done = 1'b1;
            end
         end
         ST_POLL_TX: begin
            acia_en = 1'b1;
            acia_rs = RS_STATUS;
            if (bus.acia_dout[STAT_TX_READY]) begin
               state_d = ST_WRITE_TX;
            end
         end
         ST_WRITE_TX: begin
            // Only a checksum mismatch can reach here with the error flag set.
            acia_en  = 1'b1;
            acia_we  = 1'b1;
            acia_rs  = RS_DATA;
            acia_din = error_q ? NAK_BYTE : ACK_BYTE;
            state_d  = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (data_done) begin
`ifdef LOADER_CHECKSUM_EN
         field_d = FLD_CSUM;
         state_d = ST_POLL_RX;
`else
         state_d = ST_POLL_TX;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         field_q <= FLD_SYNC;
         addr_q  <= 16'h0000;
         len_q   <= 16'h0000;
         byte_q  <= 8'h00;
         error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         byte_q  <= byte_d;
         error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign cpu_hold_o = busy_o;
   assign done_o     = (state_q == ST_FIN);
   assign error_o    = error_q;

   assign bus.acia_en   = acia_en;
   assign bus.acia_we   = acia_we;
   assign bus.acia_rs   = acia_rs;
   assign bus.acia_din  = acia_din;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_we ? addr_q : 16'h0000;
   assign bus.mem_wdata = mem_we ? byte_q : 8'h00;

endmodule

// File: tb/tb_acia_boot_loader.sv
// Bench for acia_boot_loader: ACIA/RAM responder plus a frame-level reference parser;
// honours LOADER_CHECKSUM_EN the same way as the design.
module tb_acia_boot_loader;
   import acia_pkg::*;

   localparam int TMO = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_i = 1'b0;
   logic busy_o, cpu_hold_o, done_o, error_o;

   acia_boot_loader_if bus();

   acia_boot_loader #(
      .BAUD_SEL       (4'hE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .busy_o     (busy_o),
      .cpu_hold_o (cpu_hold_o),
      .done_o     (done_o),
      .error_o    (error_o),
      .bus        (bus)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ACIA / RAM responder
   logic [7:0]  rx_mem [0:1023];
   int          rx_wr = 0;
   int          rx_rd = 0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_log[$];
   logic [23:0] mem_log[$];
   logic [7:0]  ctrl_reg = 8'h00;
   int          acia_acc = 0;
   int          done_cnt = 0;

   always_comb begin
      bus.acia_dout = 8'h00;
      if (bus.acia_rs == RS_STATUS)
         bus.acia_dout = {3'b000, tx_ready, (rx_wr != rx_rd), 3'b000};
      else if (bus.acia_rs == RS_DATA && rx_wr != rx_rd)
         bus.acia_dout = rx_mem[rx_rd[9:0]];
   end

   always @(posedge clk) begin
      if (bus.acia_en) begin
         acia_acc <= acia_acc + 1;
         if (bus.acia_we && bus.acia_rs == RS_CTRL) ctrl_reg <= bus.acia_din;
         if (bus.acia_we && bus.acia_rs == RS_DATA) tx_log.push_back(bus.acia_din);
         if (!bus.acia_we && bus.acia_rs == RS_DATA) rx_rd <= rx_rd + 1;
      end
      if (bus.mem_we) mem_log.push_back({bus.mem_addr, bus.mem_wdata});
      if (done_o) done_cnt <= done_cnt + 1;
   end

   always @(negedge clk) tx_ready <= ($urandom_range(0, 3) != 0);

   // Reference: parse the host byte stream into expected RAM writes and reply.
   logic [7:0]  stream[$];
   logic [23:0] exp_wr[$];
   int          exp_reply;
   bit          exp_err;

   function automatic void model_frame();
      int i;
      int n;
      logic [15:0] a;
      logic [7:0]  s;
      logic [7:0]  t;
      exp_wr.delete();
      exp_reply = -1;
      exp_err   = 1'b0;
      i = 0;
      while (i < stream.size() && stream[i] != 8'h4C) i++;
      i++;
      if (i + 4 > stream.size()) begin exp_err = 1'b1; return; end
      a = {stream[i], stream[i+1]};
      n = int'({stream[i+2], stream[i+3]});
      s = stream[i] + stream[i+1] + stream[i+2] + stream[i+3];
      i += 4;
      for (int k = 0; k < n; k++) begin
         if (i >= stream.size()) begin exp_err = 1'b1; return; end
         exp_wr.push_back({a, stream[i]});
         s = s + stream[i];
         a = a + 16'd1;
         i++;
      end
`ifdef LOADER_CHECKSUM_EN
      if (i >= stream.size()) begin exp_err = 1'b1; return; end
      t = s + stream[i];
      if (t == 8'h00) exp_reply = 8'h06;
      else begin exp_reply = 8'h15; exp_err = 1'b1; end
`else
      t = s;
      exp_reply = 8'h06;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      stream.push_back(b);
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_mem[rx_wr[9:0]] = b;
      rx_wr = rx_wr + 1;
   endtask

   task automatic add_csum(input bit good);
`ifdef LOADER_CHECKSUM_EN
      int i;
      logic [7:0] s;
      i = 0;
      s = 8'h00;
      while (stream[i] != 8'h4C) i++;
      for (int k = i + 1; k < stream.size(); k++) s = s + stream[k];
      s = 8'h00 - s;
      if (!good) s = s + 8'h01;
      put(s);
`endif
   endtask

   task automatic run_session(input string tag, input bit prefill, input bit extra_start);
      int d0, t0, m0, k;
      d0 = done_cnt;
      t0 = tx_log.size();
      m0 = mem_log.size();
      model_frame();
      if (prefill) foreach (stream[i]) push_byte(stream[i]);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check({tag, " busy"}, 32'(busy_o), 32'd1);
      check({tag, " hold"}, 32'(cpu_hold_o), 32'd1);
      check({tag, " err_clr"}, 32'(error_o), 32'd0);
      check({tag, " cfg_acc"}, 32'({bus.acia_en, bus.acia_we, bus.acia_rs, bus.acia_din}), 32'h0000_0F0E);
      if (prefill) begin
         @(negedge clk);
         check({tag, " poll1"}, 32'({bus.acia_en, bus.acia_we, bus.acia_rs}), 32'b1001);
         @(negedge clk);
         check({tag, " read2"}, 32'({bus.acia_en, bus.acia_we, bus.acia_rs}), 32'b1000);
      end else begin
         for (int i = 0; i < stream.size(); i++) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            push_byte(stream[i]);
            if (extra_start && i == 2) begin
               start_i = 1'b1;
               @(negedge clk);
               start_i = 1'b0;
            end
         end
      end
      k = 0;
      while (done_cnt == d0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check({tag, " busy_end"}, 32'(busy_o), 32'd0);
      check({tag, " error"}, 32'(error_o), 32'(exp_err));
      check({tag, " tx_count"}, 32'(tx_log.size() - t0), (exp_reply >= 0) ? 32'd1 : 32'd0);
      if (exp_reply >= 0 && tx_log.size() > t0)
         check({tag, " tx_byte"}, 32'(tx_log[t0]), 32'(exp_reply));
      check({tag, " wr_count"}, 32'(mem_log.size() - m0), 32'(exp_wr.size()));
      for (int j = 0; j < exp_wr.size() && m0 + j < mem_log.size(); j++)
         check({tag, " wr"}, 32'(mem_log[m0 + j]), 32'(exp_wr[j]));
      $display("session %s: bytes=%0d writes=%0d reply=%0h error=%0b", tag, stream.size(),
               mem_log.size() - m0, (tx_log.size() > t0) ? tx_log[t0] : 8'h00, error_o);
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  b;
      int n, k, acc0, mw0, m0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst busy", 32'(busy_o), 32'd0);
      check("rst hold", 32'(cpu_hold_o), 32'd0);
      check("rst done", 32'(done_o), 32'd0);
      check("rst error", 32'(error_o), 32'd0);
      check("rst acia", 32'({bus.acia_en, bus.acia_we, bus.acia_rs, bus.acia_din}), 32'd0);
      check("rst mem", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      stream.delete();
      put(8'h4C); put(8'h12); put(8'h00); put(8'h00); put(8'h03);
      put(8'hAA); put(8'hBB); put(8'hCC); add_csum(1'b1);
      run_session("frame", 1'b1, 1'b0);
      check("baud ctrl", 32'(ctrl_reg), 32'h0E);

      stream.delete();
      put(8'h4C); put(8'hFF); put(8'hFF); put(8'h00); put(8'h02);
      put(8'h11); put(8'h22); add_csum(1'b1);
      run_session("wrap", 1'b0, 1'b0);

      stream.delete();
      put(8'h00); put(8'h7F); put(8'h4C); put(8'h20); put(8'h00);
      put(8'h00); put(8'h00); add_csum(1'b1);
      run_session("junk_len0", 1'b0, 1'b1);

      stream.delete();
      put(8'h4C); put(8'h30);
      run_session("timeout", 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      stream.delete();
      put(8'h4C); put(8'h00); put(8'h10); put(8'h00); put(8'h01);
      put(8'h55); put(8'h00);
      run_session("bad_csum", 1'b0, 1'b0);
`endif

      for (int r = 0; r < 8; r++) begin
         stream.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h4C) b = 8'h00;
            put(b);
         end
         a = (r % 3 == 0) ? 16'hFFFE : 16'($urandom);
         n = $urandom_range(0, 5);
         put(8'h4C); put(a[15:8]); put(a[7:0]); put(8'h00); put(8'(n));
         repeat (n) put(8'($urandom));
         add_csum($urandom_range(0, 3) != 0);
         run_session("random", r[0], r == 5);
      end

      // Reset in the middle of the data phase.
      stream.delete();
      put(8'h4C); put(8'h40); put(8'h00); put(8'h00); put(8'h14);
      repeat (20) put(8'($urandom));
      add_csum(1'b1);
      foreach (stream[i]) push_byte(stream[i]);
      m0 = mem_log.size();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      k = 0;
      while (!(bus.mem_we && mem_log.size() >= m0 + 2) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("rst_mid reached", 32'(bus.mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mid busy", 32'(busy_o), 32'd0);
      check("rst_mid acia_en", 32'(bus.acia_en), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      acc0 = acia_acc;
      mw0  = mem_log.size();
      repeat (100) @(negedge clk);
      check("post_rst acia", 32'(acia_acc), 32'(acc0));
      check("post_rst mem", 32'(mem_log.size()), 32'(mw0));
      check("post_rst busy", 32'(busy_o), 32'd0);
      $display("session reset_mid: writes_before_reset=%0d", mw0 - m0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
